lab1_gate_checker: RTL and testbench

//   Clocked, self-checking stimulus/response checker for the Lab1 gate block.

---
 rtl/lab1_gate_checker.sv | 151 +++++++++++++++
 tb/tb_lab1_gate_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lab1_gate_checker.sv
// lab1_gate_checker: clocked stimulus/response checker for the Lab1 gate block.
// Walks vec 0..7 onto tb_a/tb_b/tb_c, holds each vector for SETTLE_CYCLES
// cycles, then samples the five gate outputs for one cycle and scores them.
// Optional feature macro: LAB1_CHK_STOP_ON_FAIL_EN (stop the run at the first
// mismatching vector). Without it every vector is always checked.
//
// Handshake: start is a single-cycle request sampled on posedge clk; it is
// honoured only in IDLE or DONE and ignored while busy. Results (done, pass,
// err_count, first_fail_*) are valid while done is high and hold until the
// next accepted start or reset.
module lab1_gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             tb_a,
  output logic             tb_b,
  output logic             tb_c,
  input  logic             L1_andOut,
  input  logic             L1_orOut,
  input  logic             L1_nandOut,
  input  logic             L1_norOut,
  input  logic             L1_notOut_a,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [2:0]       r_vec, w_vec;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [ERR_W-1:0] r_err, w_err;
  logic             r_ffv, w_ffv;
  logic [2:0]       r_ffvec, w_ffvec;

  logic [4:0]       w_exp;
  logic [4:0]       w_obs;
  logic             w_mis;

  // Golden gate response for the vector currently applied, and the observed one.
  always_comb begin
    w_exp = {&r_vec, |r_vec, ~&r_vec, ~|r_vec, ~r_vec[2]};
    w_obs = {L1_andOut, L1_orOut, L1_nandOut, L1_norOut, L1_notOut_a};
    w_mis = (w_exp != w_obs);
  end

  // State and result registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_ffv   <= 1'b0;
      r_ffvec <= '0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_cnt   <= w_cnt;
      r_err   <= w_err;
      r_ffv   <= w_ffv;
      r_ffvec <= w_ffvec;
    end
  end

  // Next-state and next-result logic.
  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_cnt   = r_cnt;
    w_err   = r_err;
    w_ffv   = r_ffv;
    w_ffvec = r_ffvec;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state = S_SETTLE;
          w_vec   = '0;
          w_cnt   = '0;
          w_err   = '0;
          w_ffv   = 1'b0;
          w_ffvec = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_MAX) begin
          w_state = S_SAMPLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (w_mis) begin
          if (r_err != ERR_MAX) w_err = r_err + 1'b1;
          if (!r_ffv) begin
            w_ffv   = 1'b1;
            w_ffvec = r_vec;
          end
        end
`ifdef LAB1_CHK_STOP_ON_FAIL_EN
        if (w_mis || r_vec == 3'd7) begin
          w_state = S_DONE;
        end else begin
          w_vec   = r_vec + 3'd1;
          w_cnt   = '0;
          w_state = S_SETTLE;
        end
`else
        if (r_vec == 3'd7) begin
          w_state = S_DONE;
        end else begin
          w_vec   = r_vec + 3'd1;
          w_cnt   = '0;
          w_state = S_SETTLE;
        end
`endif
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Output decode: stimulus is driven only while a vector is being checked.
  always_comb begin
    busy             = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    done             = (r_state == S_DONE);
    pass             = done && (r_err == '0);
    {tb_a, tb_b, tb_c} = busy ? r_vec : 3'b000;
    err_count        = r_err;
    first_fail_valid = r_ffv;
    first_fail_vec   = r_ffvec;
    dbg_state        = r_state;
  end

endmodule

// File: tb/tb_lab1_gate_checker.sv
// tb_lab1_gate_checker: exercises lab1_gate_checker against a gate model with
// per-vector fault masks (bit order and,or,nand,nor,not_a). The reference
// model scores the eight vectors directly from the masks.
module tb_lab1_gate_checker;

  localparam int S     = 2;
  localparam int ERR_W = 3;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int LIMIT = 200;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             tb_a, tb_b, tb_c;
  logic             and_o, or_o, nand_o, nor_o, not_o;
  logic             busy, done, pass, ffv;
  logic [ERR_W-1:0] err_count;
  logic [2:0]       ffvec;
  logic [1:0]       dbg_state;

  logic [4:0]       fmask [8];
  logic [2:0]       exp_q [$];
  logic [2:0]       vin;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Gate block model: ideal gates with the fault mask for the applied vector.
  always_comb begin
    vin    = {tb_a, tb_b, tb_c};
    and_o  = (tb_a & tb_b & tb_c)    ^ fmask[vin][4];
    or_o   = (tb_a | tb_b | tb_c)    ^ fmask[vin][3];
    nand_o = ~(tb_a & tb_b & tb_c)   ^ fmask[vin][2];
    nor_o  = ~(tb_a | tb_b | tb_c)   ^ fmask[vin][1];
    not_o  = ~tb_a                   ^ fmask[vin][0];
  end

  lab1_gate_checker #(.SETTLE_CYCLES(S), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .tb_a(tb_a), .tb_b(tb_b), .tb_c(tb_c),
    .L1_andOut(and_o), .L1_orOut(or_o), .L1_nandOut(nand_o),
    .L1_norOut(nor_o), .L1_notOut_a(not_o),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_valid(ffv), .first_fail_vec(ffvec), .dbg_state(dbg_state)
  );

  task automatic set_mask(input logic [4:0] m, input int only_v);
    for (int v = 0; v < 8; v++) fmask[v] = (only_v < 0 || only_v == v) ? m : 5'd0;
  endtask

  // One full run. Cycle 0 is the cycle start is held high; cycle t begins at
  // the t-th rising edge after that. restart_t/reset_t inject start/reset
  // during that cycle (-1 = none).
  task automatic run_check(input string name, input int restart_t, input int reset_t);
    int n_bad, first_v, k_last, exp_done_t, exp_err, t;
    bit seen;
    logic [2:0] ev;
    n_bad = 0; first_v = -1; k_last = 7;
    for (int v = 0; v < 8; v++) begin
      if (fmask[v] != 5'd0) begin
        n_bad++;
        if (first_v < 0) first_v = v;
`ifdef LAB1_CHK_STOP_ON_FAIL_EN
        k_last = v;
        break;
`endif
      end
    end
    exp_err    = (n_bad > ERR_MAX) ? ERR_MAX : n_bad;
    exp_done_t = (k_last + 1) * (S + 1) + 1;
    exp_q.delete();
    for (int v = 0; v <= k_last; v++)
      for (int c = 0; c <= S; c++) exp_q.push_back(3'(v));

    @(posedge clk); #1 start = 1'b1;
    t = 0; seen = 1'b0;
    while (!seen && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
      end else begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s overrun: still busy at cycle %0d, required done at %0d", name, t, exp_done_t);
          ev = 3'd0;
        end else begin
          ev = exp_q.pop_front();
        end
        n_checks++;
        if ({busy, tb_a, tb_b, tb_c} !== {1'b1, ev}) begin
          n_fail++;
          $display("FAIL %s stim cycle %0d: busy,vec=%b required %b", name, t, {busy, tb_a, tb_b, tb_c}, {1'b1, ev});
        end
        if (t == restart_t) start = 1'b1;
        if (t == reset_t) begin
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          n_checks++;
          if ({tb_a, tb_b, tb_c, busy, done, pass, err_count, ffv, ffvec} !== '0) begin
            n_fail++;
            $display("FAIL %s reset_abort: outputs=%b required all zero", name,
                     {tb_a, tb_b, tb_c, busy, done, pass, err_count, ffv, ffvec});
          end
          return;
        end
      end
    end
    n_checks++;
    if (!seen || t != exp_done_t) begin
      n_fail++;
      $display("FAIL %s done_cycle: done seen=%0d at cycle %0d, required cycle %0d", name, seen, t, exp_done_t);
    end
    n_checks++;
    if (err_count !== ERR_W'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d required %0d", name, err_count, exp_err);
    end
    n_checks++;
    if (ffv !== (n_bad > 0) || (n_bad > 0 && ffvec !== 3'(first_v)) || (n_bad == 0 && ffvec !== 3'd0)) begin
      n_fail++;
      $display("FAIL %s first_fail: valid=%b vec=%0d required valid=%b vec=%0d", name, ffv, ffvec,
               (n_bad > 0), (n_bad > 0) ? first_v : 0);
    end
    n_checks++;
    if ({pass, busy, tb_a, tb_b, tb_c} !== {(n_bad == 0), 4'b0000}) begin
      n_fail++;
      $display("FAIL %s done_outputs: pass,busy,vec=%b required %b", name, {pass, busy, tb_a, tb_b, tb_c},
               {(n_bad == 0), 4'b0000});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, pass, err_count} !== {1'b1, (n_bad == 0), ERR_W'(exp_err)}) begin
      n_fail++;
      $display("FAIL %s done_hold: done,pass,err=%b required %b", name, {done, pass, err_count},
               {1'b1, (n_bad == 0), ERR_W'(exp_err)});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({tb_a, tb_b, tb_c, busy, done, pass, err_count, ffv, ffvec} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%b required all zero", {tb_a, tb_b, tb_c, busy, done, pass, err_count, ffv, ffvec});
    end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy,done=%b required 00", {busy, done});
    end
  endtask

  task automatic test_all_pass();      set_mask(5'd0, -1);      run_check("all_pass", -1, -1); endtask
  task automatic test_and_stuck0();    set_mask(5'b10000, 7);   run_check("and_stuck0", -1, -1); endtask
  task automatic test_not_inverted();  set_mask(5'b00001, -1);  run_check("not_inverted", -1, -1); endtask
  task automatic test_or_stuck1();     set_mask(5'b01000, 0);   run_check("or_stuck1", -1, -1); endtask
  task automatic test_start_while_busy(); set_mask(5'd0, -1);   run_check("start_busy", 7, -1); endtask

  task automatic test_reset_mid_run();
    set_mask(5'd0, -1);
    run_check("reset_mid", -1, 4 * (S + 1) + (S + 1));
    run_check("after_reset", -1, -1);
  endtask

  task automatic test_back_to_back();
    set_mask(5'b00100, 3); run_check("b2b_fail", -1, -1);
    set_mask(5'd0, -1);    run_check("b2b_pass", -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 8; v++)
        fmask[v] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      run_check($sformatf("random%0d", r), -1, -1);
    end
  endtask

  initial begin
    set_mask(5'd0, -1);
    test_reset();
    test_all_pass();
    test_and_stuck0();
    test_not_inverted();
    test_reset_mid_run();
    test_start_while_busy();
    test_or_stuck1();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
